// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg
// Shared helpers for the fifo_flex block.
//   ptr_w(depth)  : width of a pointer that ranges over 0..depth-1
//   cnt_w(depth)  : width of an occupancy counter that ranges over 0..depth
// Also provides FIFO_FLEX_CHECK_LEVELS, an elaboration-time range check for
// the depth and the almost-full / almost-empty thresholds.
// Optional feature macro used by fifo_flex: FIFO_FLEX_FWFT_EN.

`ifndef FIFO_FLEX_PKG_SV
`define FIFO_FLEX_PKG_SV

// Expands to a generate-if that stops elaboration on an illegal configuration.
`define FIFO_FLEX_CHECK_LEVELS(depth, af, ae) \
    if ((depth) < 2 || (af) < 1 || (af) > (depth) || (ae) < 0 || (ae) > (depth) - 1) begin : g_bad_levels \
        $error("fifo_flex: DEPTH must be >= 2, AF_LVL in 1..DEPTH, AE_LVL in 0..DEPTH-1"); \
    end

package fifo_flex_pkg;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`endif

// File: rtl/fifo_flex_ptr.sv
// fifo_flex_ptr
// Wrap-around pointer over 0..DEPTH-1. The wrap is an explicit compare
// against DEPTH-1 so any depth works, not only powers of two.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (pointer returns to 0)
//   inc  : advance the pointer by one position this cycle
//   ptr  : current pointer value

module fifo_flex_ptr
    import fifo_flex_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex
// Synchronous FIFO with configurable width and any depth >= 2, occupancy
// count, programmable almost-full / almost-empty flags and one-cycle
// overflow / underflow pulses.
// Build option: define FIFO_FLEX_FWFT_EN for first-word-fall-through reads
// (Dout shows the head word combinationally); otherwise Dout is a register
// loaded by each accepted pop.
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   push, Din    : write request and write data
//   pop          : read request
//   Dout         : read data
//   full         : count == DEPTH
//   pndng        : count != 0
//   almost_full  : count >= AF_LVL
//   almost_empty : count <= AE_LVL
//   count        : current occupancy
//   ovf, udf     : one-cycle pulses for a rejected push / rejected pop
//
// Handshake: push and pop are requests sampled at the rising edge against
// the registered state. A pop is accepted when the FIFO holds data. A push is
// accepted when the FIFO is not full, or when it is full and a pop is accepted
// on the same edge. A rejected request is dropped (not retried) and reported
// by ovf/udf in the following cycle. All status outputs decode from the
// registered count only, so no output depends combinationally on push/pop.

module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BITS-1:0]          Din,
    input  logic                     pop,
    output logic [BITS-1:0]          Dout,
    output logic                     full,
    output logic                     pndng,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    `FIFO_FLEX_CHECK_LEVELS(DEPTH, AF_LVL, AE_LVL)

    logic [BITS-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic            push_ok;
    logic            pop_ok;

    // Status flags from the registered count only.
    assign full         = (count == CW'(DEPTH));
    assign pndng        = (count != '0);
    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));

    // Pop is judged first so a full FIFO can take a push in the same cycle
    // it frees a slot. On an empty FIFO the pop is refused and the push wins.
    assign pop_ok  = pop & pndng;
    assign push_ok = push & (~full | pop_ok);

    fifo_flex_ptr #(.DEPTH(DEPTH)) u_wp (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .ptr (wp)
    );

    fifo_flex_ptr #(.DEPTH(DEPTH)) u_rp (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .ptr (rp)
    );

    // Storage is intentionally not reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= Din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= push & ~push_ok;
            udf <= pop & ~pop_ok;
        end
    end

`ifdef FIFO_FLEX_FWFT_EN
    // Head word is visible as soon as it is stored; forced to 0 when empty.
    assign Dout = pndng ? mem[rp] : '0;
`else
    // Registered read: the popped word appears the cycle after the pop and
    // is held until the next accepted pop, even once the FIFO is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Dout <= '0;
        end else if (pop_ok) begin
            Dout <= mem[rp];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex
// Directed bench for fifo_flex: a DEPTH=4 instance for reset, fill, flags,
// overflow/underflow, simultaneous push/pop and reset mid-burst, and a DEPTH=5
// instance for pointer wrap on a non-power-of-two depth. Read-data checks
// follow the build mode (FIFO_FLEX_FWFT_EN or registered read).

`timescale 1ns/1ps

module tb_fifo_flex;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DEPTH=4 instance ----------------
    logic       push4, pop4;
    logic [7:0] din4, dout4;
    logic       full4, pndng4, af4, ae4, ovf4, udf4;
    logic [2:0] count4;

    fifo_flex #(.BITS(8), .DEPTH(4), .AF_LVL(3), .AE_LVL(1)) u4 (
        .clk          (clk),
        .rst          (rst),
        .push         (push4),
        .Din          (din4),
        .pop          (pop4),
        .Dout         (dout4),
        .full         (full4),
        .pndng        (pndng4),
        .almost_full  (af4),
        .almost_empty (ae4),
        .count        (count4),
        .ovf          (ovf4),
        .udf          (udf4)
    );

    // ---------------- DEPTH=5 instance ----------------
    logic       push5, pop5;
    logic [7:0] din5, dout5;
    logic       full5, pndng5, af5, ae5, ovf5, udf5;
    logic [2:0] count5;

    fifo_flex #(.BITS(8), .DEPTH(5)) u5 (
        .clk          (clk),
        .rst          (rst),
        .push         (push5),
        .Din          (din5),
        .pop          (pop5),
        .Dout         (dout5),
        .full         (full5),
        .pndng        (pndng5),
        .almost_full  (af5),
        .almost_empty (ae5),
        .count        (count5),
        .ovf          (ovf5),
        .udf          (udf5)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] head;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- drivers ----------------
    // Drive for one edge, then check 1ns after the edge.
    task automatic cyc4(input logic p, input logic [7:0] d, input logic q);
        push4 = p; din4 = d; pop4 = q;
        @(posedge clk);
        #1;
        push4 = 1'b0; pop4 = 1'b0;
    endtask

    task automatic cyc5(input logic p, input logic [7:0] d, input logic q);
        push5 = p; din5 = d; pop5 = q;
        @(posedge clk);
        #1;
        push5 = 1'b0; pop5 = 1'b0;
    endtask

    // Pop one word from u4 (optionally pushing too) and check read data
    // against the scoreboard head, in the timing of the build mode.
    task automatic pop4_check(input string tag, input logic p, input logic [7:0] d);
        head = exp_q.pop_front();
        if (p) exp_q.push_back(d);
`ifdef FIFO_FLEX_FWFT_EN
        check(tag, dout4, head);
        cyc4(p, d, 1'b1);
`else
        cyc4(p, d, 1'b1);
        check(tag, dout4, head);
`endif
    endtask

    task automatic pop5_check(input string tag, input logic p, input logic [7:0] d);
        head = exp_q.pop_front();
        if (p) exp_q.push_back(d);
`ifdef FIFO_FLEX_FWFT_EN
        check(tag, dout5, head);
        cyc5(p, d, 1'b1);
`else
        cyc5(p, d, 1'b1);
        check(tag, dout5, head);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        push4 = 1'b0; pop4 = 1'b0; din4 = '0;
        push5 = 1'b0; pop5 = 1'b0; din5 = '0;
        #12;

        // Reset state
        check("rst_count", count4, 0);
        check("rst_pndng", pndng4, 0);
        check("rst_full", full4, 0);
        check("rst_af", af4, 0);
        check("rst_ae", ae4, 1);
        check("rst_dout", dout4, 0);
        check("rst_ovf", ovf4, 0);
        check("rst_udf", udf4, 0);
        @(negedge clk);
        rst = 1'b1;

        // Fill 0x11..0x44
        cyc4(1'b1, 8'h11, 1'b0); exp_q.push_back(8'h11);
        check("fill1_count", count4, 1);
        check("fill1_pndng", pndng4, 1);
        check("fill1_ae", ae4, 1);
        cyc4(1'b1, 8'h22, 1'b0); exp_q.push_back(8'h22);
        check("fill2_ae", ae4, 0);
        check("fill2_af", af4, 0);
        cyc4(1'b1, 8'h33, 1'b0); exp_q.push_back(8'h33);
        check("fill3_af", af4, 1);
        check("fill3_full", full4, 0);
        cyc4(1'b1, 8'h44, 1'b0); exp_q.push_back(8'h44);
        check("fill4_count", count4, 4);
        check("fill4_full", full4, 1);

        // Push while full: rejected, ovf for exactly one cycle
        cyc4(1'b1, 8'h99, 1'b0);
        check("ovf_pulse", ovf4, 1);
        check("ovf_count", count4, 4);
        cyc4(1'b0, 8'h00, 1'b0);
        check("ovf_clear", ovf4, 0);

        // Push with pop at full: both accepted, count unchanged, no ovf
        pop4_check("sim_full_dout", 1'b1, 8'h55);
        check("sim_full_count", count4, 4);
        check("sim_full_ovf", ovf4, 0);
        check("sim_full_full", full4, 1);

        // Drain: 0x22, 0x33, 0x44, 0x55 (0x99 must never appear)
        pop4_check("drain1", 1'b0, 8'h00);
        check("drain1_full", full4, 0);
        pop4_check("drain2", 1'b0, 8'h00);
        pop4_check("drain3", 1'b0, 8'h00);
        check("drain3_count", count4, 1);
        pop4_check("drain4", 1'b0, 8'h00);
        check("drain4_pndng", pndng4, 0);
        check("drain4_count", count4, 0);
`ifdef FIFO_FLEX_FWFT_EN
        check("empty_dout", dout4, 8'h00);
`else
        check("empty_dout_hold", dout4, 8'h55);
`endif

        // Pop while empty: udf pulse, Dout unchanged
        cyc4(1'b0, 8'h00, 1'b1);
        check("udf_pulse", udf4, 1);
        check("udf_count", count4, 0);
`ifdef FIFO_FLEX_FWFT_EN
        check("udf_dout", dout4, 8'h00);
`else
        check("udf_dout", dout4, 8'h55);
`endif
        cyc4(1'b0, 8'h00, 1'b0);
        check("udf_clear", udf4, 0);

        // Push with pop at empty: pop refused, push taken
        cyc4(1'b1, 8'h66, 1'b1);
        check("sim_empty_udf", udf4, 1);
        check("sim_empty_count", count4, 1);
        check("sim_empty_ovf", ovf4, 0);
        exp_q.push_back(8'h66);
        pop4_check("sim_empty_read", 1'b0, 8'h00);
        check("sim_empty_udf_clear", udf4, 0);

        // Single word: visible next cycle in FWFT, then read back
        cyc4(1'b1, 8'hA5, 1'b0);
`ifdef FIFO_FLEX_FWFT_EN
        check("fwft_a5", dout4, 8'hA5);
`else
        check("std_hold_66", dout4, 8'h66);
`endif
        exp_q.push_back(8'hA5);
        pop4_check("a5_read", 1'b0, 8'h00);
        check("a5_pndng", pndng4, 0);

        // Reset mid-burst: clears immediately, before any clock edge
        cyc4(1'b1, 8'h01, 1'b0);
        cyc4(1'b1, 8'h02, 1'b0);
        cyc4(1'b1, 8'h03, 1'b0);
        check("burst_count", count4, 3);
        #2 rst = 1'b0;
        #1;
        check("midrst_count", count4, 0);
        check("midrst_pndng", pndng4, 0);
        check("midrst_ae", ae4, 1);
        check("midrst_dout", dout4, 0);
        @(negedge clk);
        rst = 1'b1;

        // DEPTH=5: prefill two, 12 push/pop pairs, drain two; pointers wrap 4->0
        exp_q.delete();
        cyc5(1'b1, 8'h01, 1'b0); exp_q.push_back(8'h01);
        cyc5(1'b1, 8'h02, 1'b0); exp_q.push_back(8'h02);
        check("d5_prefill_count", count5, 2);
        for (int i = 0; i < 12; i++) begin
            pop5_check($sformatf("d5_pair%0d", i), 1'b1, 8'(i + 3));
            check($sformatf("d5_pair%0d_count", i), count5, 2);
        end
        pop5_check("d5_drain1", 1'b0, 8'h00);
        pop5_check("d5_drain2", 1'b0, 8'h00);
        check("d5_empty", pndng5, 0);
        check("d5_no_ovf", ovf5, 0);
        check("d5_no_udf", udf5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
